// File: rtl/z3_slave_engine_if.sv
// Zorro III slave engine bus bundle: FCS-qualified front-end inputs,
// per-target select/ready/start lines and the engine's response outputs.
interface z3_slave_engine_if #(
    parameter int NUM_TARGETS = 4,
    parameter int BEAT_W      = 8
);
    logic                   bfcs;
    logic                   match;
    logic                   validspace;
    logic                   read;
    logic [3:0]             ds_n;
    logic                   mtcr_n;
    logic [NUM_TARGETS-1:0] tgt_sel;
    logic [NUM_TARGETS-1:0] tgt_ready;
    logic [NUM_TARGETS-1:0] tgt_start;
    logic [NUM_TARGETS-1:0] active_tgt;
    logic                   dtack;
    logic                   berr;
    logic                   cycle_active;
    logic [BEAT_W-1:0]      beat_count;

    // The engine itself
    modport slave (
        input  bfcs, match, validspace, read, ds_n, mtcr_n, tgt_sel, tgt_ready,
        output tgt_start, active_tgt, dtack, berr, cycle_active, beat_count
    );

    // Bus front end plus targets driving the engine
    modport master (
        output bfcs, match, validspace, read, ds_n, mtcr_n, tgt_sel, tgt_ready,
        input  tgt_start, active_tgt, dtack, berr, cycle_active, beat_count
    );
endinterface

// File: rtl/z3_slave_engine.sv
// Zorro III slave cycle engine: dispatches each FCS cycle to one local
// target, returns DTACK, supports MTCR_n multiple-transfer bursts, raises
// BERR when the owning target stays silent too long, and counts beats.
module z3_slave_engine #(
    parameter int NUM_TARGETS    = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MT_ENABLE      = 1,
    parameter int BEAT_W         = 8
) (
    input  logic              CLK,
    input  logic              RESET_n,
    z3_slave_engine_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        MT_WAIT,
        ERR
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic        MT_ON      = (MT_ENABLE != 0);

    state_t                 state_reg;
    logic [NUM_TARGETS-1:0] active_reg;
    logic [NUM_TARGETS-1:0] start_reg;
    logic                   dtack_reg;
    logic                   berr_reg;
    logic                   cycle_reg;
    logic [BEAT_W-1:0]      beat_reg;
    logic [15:0]            timer_reg;

    logic [NUM_TARGETS-1:0] sel_lowest;
    logic                   sel_any;
    logic                   strobe_seen;
    logic                   ready_hit;
    logic                   beat_full;

    // Fixed-priority pick: a target wins only if no lower-index target is selected
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_pick
            localparam logic [NUM_TARGETS-1:0] LOWER = NUM_TARGETS'((64'd1 << gi) - 64'd1);
            assign sel_lowest[gi] = bus.tgt_sel[gi] & ~|(bus.tgt_sel & LOWER);
        end
    endgenerate

    assign sel_any     = |bus.tgt_sel;
    // A data phase may begin on a read, or on a write once any data strobe is low
    assign strobe_seen = bus.read || (bus.ds_n != 4'hF);
    // Only the owning target's ready line matters
    assign ready_hit   = |(bus.tgt_ready & active_reg);
    assign beat_full   = &beat_reg;

    // Cycle FSM with all outputs registered; losing FCS always aborts to IDLE
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg  <= IDLE;
            active_reg <= '0;
            start_reg  <= '0;
            dtack_reg  <= 1'b0;
            berr_reg   <= 1'b0;
            cycle_reg  <= 1'b0;
            beat_reg   <= '0;
            timer_reg  <= '0;
        end else begin
            start_reg <= '0;
            if (!bus.bfcs) begin
                state_reg  <= IDLE;
                active_reg <= '0;
                dtack_reg  <= 1'b0;
                berr_reg   <= 1'b0;
                cycle_reg  <= 1'b0;
                beat_reg   <= '0;
                timer_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.match && bus.validspace && sel_any) begin
                            state_reg  <= START;
                            active_reg <= sel_lowest;
                            cycle_reg  <= 1'b1;
                        end
                    end
                    START, MT_WAIT: begin
                        // First beat needs only a strobe; later beats also need MTCR_n low
                        if (strobe_seen && (state_reg == START || !bus.mtcr_n)) begin
                            state_reg <= DATA;
                            start_reg <= active_reg;
                            timer_reg <= '0;
                        end
                    end
                    DATA: begin
                        if (ready_hit) begin
                            state_reg <= ACK;
                            dtack_reg <= 1'b1;
                            beat_reg  <= beat_full ? beat_reg : beat_reg + 1'b1;
                        end else if (timer_reg == TIMER_LAST) begin
                            state_reg <= ERR;
                            berr_reg  <= 1'b1;
                        end else begin
                            timer_reg <= timer_reg + 16'd1;
                        end
                    end
                    ACK: begin
                        // MTCR_n negating ends this beat of a burst
                        if (MT_ON && bus.mtcr_n) begin
                            state_reg <= MT_WAIT;
                            dtack_reg <= 1'b0;
                        end
                    end
                    ERR: begin
                        berr_reg <= 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tgt_start    = start_reg;
    assign bus.active_tgt   = active_reg;
    assign bus.dtack        = dtack_reg;
    assign bus.berr         = berr_reg;
    assign bus.cycle_active = cycle_reg;
    assign bus.beat_count   = beat_reg;

endmodule

// File: tb/tb_z3_slave_engine.sv
// Self-checking bench for z3_slave_engine: a cycle-level behavioural model
// is compared against the DUT every cycle, plus directed literal checks.
module tb_z3_slave_engine;

    localparam int NT = 4;
    localparam int TO = 8;
    localparam int BW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    z3_slave_engine_if #(.NUM_TARGETS(NT), .BEAT_W(BW)) bus ();

    z3_slave_engine #(
        .NUM_TARGETS    (NT),
        .TIMEOUT_CYCLES (TO),
        .MT_ENABLE      (1),
        .BEAT_W         (BW)
    ) dut (
        .CLK     (clk),
        .RESET_n (rst_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // busy: a cycle is claimed; awaiting: waiting for a data strobe (and for
    // MTCR_n low when between burst beats); in_data: waiting on the target.
    logic          busy = 0, awaiting = 0, between = 0, in_data = 0;
    int            elapsed = 0;
    int            e_beats = 0;
    logic [NT-1:0] e_owner = '0, e_start = '0;
    logic          e_dtack = 0, e_berr = 0;

    task automatic model_clear();
        busy = 0; awaiting = 0; between = 0; in_data = 0; elapsed = 0;
        e_beats = 0; e_owner = '0; e_start = '0; e_dtack = 0; e_berr = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            e_start = '0;
            if (!bus.bfcs) begin
                model_clear();
            end else if (!busy) begin
                if (bus.match && bus.validspace && bus.tgt_sel != 0) begin
                    busy     = 1;
                    e_owner  = bus.tgt_sel & (-bus.tgt_sel);
                    awaiting = 1;
                    between  = 0;
                end
            end else if (awaiting) begin
                if ((bus.read || bus.ds_n != 4'hF) && (!between || !bus.mtcr_n)) begin
                    awaiting = 0;
                    in_data  = 1;
                    elapsed  = 0;
                    e_start  = e_owner;
                end
            end else if (in_data) begin
                if ((bus.tgt_ready & e_owner) != 0) begin
                    in_data = 0;
                    e_dtack = 1;
                    e_beats = (e_beats < 255) ? e_beats + 1 : 255;
                end else if (elapsed == TO - 1) begin
                    in_data = 0;
                    e_berr  = 1;
                end else begin
                    elapsed++;
                end
            end else if (e_dtack) begin
                if (bus.mtcr_n) begin
                    e_dtack  = 0;
                    awaiting = 1;
                    between  = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_start = 0;
    always @(negedge clk) begin
        check("tgt_start",    bus.tgt_start,    e_start);
        check("active_tgt",   bus.active_tgt,   e_owner);
        check("dtack",        bus.dtack,        e_dtack);
        check("berr",         bus.berr,         e_berr);
        check("cycle_active", bus.cycle_active, busy);
        check("beat_count",   bus.beat_count,   e_beats);
        check("dtack_berr_excl", bus.dtack & bus.berr, 0);
        check("start_gap", (|bus.tgt_start) & prev_start, 0);
        prev_start = |bus.tgt_start;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_bus();
        bus.bfcs = 0; bus.match = 0; bus.validspace = 0; bus.read = 0;
        bus.ds_n = 4'hF; bus.mtcr_n = 1; bus.tgt_sel = '0; bus.tgt_ready = '0;
    endtask

    task automatic open_cycle(input logic [NT-1:0] sel, input logic rd);
        bus.match = 1; bus.validspace = 1; bus.tgt_sel = sel;
        bus.read = rd; bus.ds_n = 4'hF; bus.bfcs = 1;
    endtask

    task automatic wait_start(input string name, output bit ok);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.tgt_start != 0) begin ok = 1; break; end
        end
        if (!ok) expired(name);
    endtask

    task automatic wait_dtack(input string name, output bit ok);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.dtack) begin ok = 1; break; end
        end
        if (!ok) expired(name);
    endtask

    task automatic end_cycle();
        idle_bus();
        @(negedge clk);
        check("end_idle", {bus.cycle_active, bus.dtack, bus.berr, bus.active_tgt}, 0);
    endtask

    // MTCR_n burst of nbeats beats; tgt_sel is scrambled mid-burst
    task automatic run_burst(input int nbeats, input logic [NT-1:0] sel, input logic [NT-1:0] owner);
        bit ok;
        int starts, acks;
        starts = 0; acks = 0;
        open_cycle(sel, 1'b1);
        bus.mtcr_n = 0;
        for (int b = 0; b < nbeats; b++) begin
            wait_start("burst_start", ok);
            if (!ok) break;
            starts++;
            bus.tgt_sel   = ~sel;
            bus.tgt_ready = owner;
            wait_dtack("burst_dtack", ok);
            if (!ok) break;
            acks++;
            bus.tgt_ready = '0;
            if (b != nbeats - 1) begin
                bus.mtcr_n = 1;
                @(negedge clk);
                check("burst_gap_dtack", bus.dtack, 0);
                bus.mtcr_n = 0;
            end
        end
        check("burst_starts", starts, nbeats);
        check("burst_acks", acks, nbeats);
        check("burst_owner", bus.active_tgt, owner);
        check("burst_beats", bus.beat_count, (nbeats > 255) ? 255 : nbeats);
        $display("txn burst beats=%0d owner=%b beat_count=%0d", nbeats, owner, bus.beat_count);
        end_cycle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        idle_bus();
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_state", {bus.cycle_active, bus.dtack, bus.berr, bus.tgt_start,
                              bus.active_tgt, bus.beat_count}, 0);
        rst_n = 1;
        @(negedge clk);

        // Single read, target 2 ready three clocks after the data phase opens
        open_cycle(4'b0100, 1'b1);
        @(negedge clk);
        check("rd_active", bus.active_tgt, 4'b0100);
        check("rd_no_start_yet", bus.tgt_start, 0);
        @(negedge clk);
        check("rd_start_pulse", bus.tgt_start, 4'b0100);
        @(negedge clk);
        check("rd_start_once", bus.tgt_start, 0);
        @(negedge clk);
        bus.tgt_ready = 4'b0100;
        @(negedge clk);
        check("rd_dtack", bus.dtack, 1);
        check("rd_beats", bus.beat_count, 1);
        $display("txn single_read dtack=%0d beats=%0d", bus.dtack, bus.beat_count);
        end_cycle();

        // Write gating: no data phase until a data strobe is seen
        open_cycle(4'b0001, 1'b0);
        @(negedge clk);
        check("wr_active", bus.active_tgt, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wr_gated", bus.tgt_start, 0);
        end
        bus.ds_n = 4'h0;
        @(negedge clk);
        check("wr_start_pulse", bus.tgt_start, 4'b0001);
        bus.tgt_ready = 4'b0001;
        @(negedge clk);
        check("wr_dtack", bus.dtack, 1);
        $display("txn write_gated dtack=%0d", bus.dtack);
        end_cycle();

        // Timeout: target never ready, BERR exactly TO clocks after data entry
        open_cycle(4'b1000, 1'b1);
        wait_start("to_start", ok);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check("to_berr", bus.berr, (i == TO) ? 1 : 0);
            check("to_no_dtack", bus.dtack, 0);
        end
        repeat (2) @(negedge clk);
        check("to_berr_held", bus.berr, 1);
        $display("txn timeout berr=%0d", bus.berr);
        end_cycle();

        // Ready on the very edge the timeout would fire: ready wins
        open_cycle(4'b0001, 1'b1);
        wait_start("race_start", ok);
        repeat (TO - 1) @(negedge clk);
        bus.tgt_ready = 4'b0001;
        @(negedge clk);
        check("race_dtack", bus.dtack, 1);
        check("race_no_berr", bus.berr, 0);
        $display("txn ready_vs_timeout dtack=%0d berr=%0d", bus.dtack, bus.berr);
        end_cycle();

        // Bursts: four beats, then one long enough to saturate the counter
        run_burst(4, 4'b0010, 4'b0010);
        run_burst(260, 4'b0001, 4'b0001);

        // Arbitration: lowest selected index wins
        open_cycle(4'b0110, 1'b0);
        @(negedge clk);
        check("arb_owner", bus.active_tgt, 4'b0010);
        $display("txn arbitration sel=0110 owner=%b", bus.active_tgt);
        end_cycle();

        // No target selected: no claim at all
        open_cycle(4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nosel_idle", {bus.cycle_active, bus.dtack, bus.berr}, 0);
        end
        $display("txn no_target cycle_active=%0d", bus.cycle_active);
        end_cycle();

        // Asynchronous reset in the middle of a data phase
        open_cycle(4'b0001, 1'b1);
        wait_start("rst_start", ok);
        @(negedge clk);
        check("rst_pre_active", bus.cycle_active, 1);
        #2 rst_n = 0;
        #1;
        check("rst_async_clear", {bus.cycle_active, bus.dtack, bus.berr, bus.tgt_start,
                                  bus.active_tgt, bus.beat_count}, 0);
        idle_bus();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        open_cycle(4'b0100, 1'b1);
        wait_start("post_rst_start", ok);
        check("post_rst_start_tgt", bus.tgt_start, 4'b0100);
        bus.tgt_ready = 4'b0100;
        wait_dtack("post_rst_dtack", ok);
        check("post_rst_beats", bus.beat_count, 1);
        $display("txn reset_recovery beats=%0d", bus.beat_count);
        end_cycle();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
